frame_reg_bank: RTL and testbench
=================================

FRAME_REG_BANK -- requirements
Module: frame_reg_bank

Interface
REQ-001 Parameter DATA_W, default 16, register width in bits.
REQ-002 Parameter NUM_REGS, default 10, number of game-state registers (2..16).
REQ-003 Parameter ADDR_W, default 4, width of data_address.
REQ-004 Parameter H_LAST / V_LAST, default 639 / 479, last visible pixel coordinates.
REQ-005 Parameter RESET_VALS, default {0,0,0,500,240,320,240,320,240,320} (reg9..reg0, DATA_W each), reset contents.
REQ-006 Parameter CLEAR_TRIG_IDX, default 9, game_state register index; parameter CLEAR_MASK, default 10'b0110000000, registers cleared on trigger.
REQ-007 Parameter READ_SRC, default 0, read-back source: 0 = shadow, 1 = active.
REQ-008 clk  input  1  single clock, all logic on rising edge.
REQ-009 rst  input  1  synchronous, active-low reset.
REQ-010 chipselect  input  1  bus access strobe, one access per asserted cycle.
REQ-011 read  input  1  1 = read, 0 = write (qualified by chipselect).
REQ-012 data_address  input  ADDR_W  register index.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 VGA_ready  input  1  pixel pipeline advancing.
REQ-015 pixel_x / pixel_y  input  16 each  current scan coordinates.
REQ-016 lock  input  1  commit inhibit.
REQ-017 rd_data  output  DATA_W  read data; rd_valid  output  1  read data strobe.
REQ-018 active_regs  output  NUM_REGS*DATA_W  committed registers, reg0 in LSBs.
REQ-019 commit_pulse  output  1  one-cycle strobe after each commit.
REQ-020 dirty  output  NUM_REGS  per-register written-since-commit flags.
REQ-021 addr_err  output  1  one-cycle strobe for out-of-range access.
REQ-022 missed_frames  output  8  frame ends skipped while lock held with pending data.

Function
REQ-023 Two arrays SHALL exist: shadow (bus-written) and active (drives active_regs).
REQ-024 Write: chipselect & ~read & data_address<NUM_REGS SHALL set shadow[addr]<=wr_data and dirty[addr]<=1 at the next edge.
REQ-025 Write to CLEAR_TRIG_IDX with wr_data!=0 SHALL in the same edge zero every shadow register whose CLEAR_MASK bit is set, and set their dirty bits; the trigger register takes wr_data.
REQ-026 Read: chipselect & read SHALL give rd_data = selected array[addr] and rd_valid=1 one cycle later; rd_data holds its value otherwise, rd_valid=0.
REQ-027 Out-of-range address (>=NUM_REGS), read or write: no state change, rd_data=0 with rd_valid=1 for reads, addr_err=1 the next cycle.
REQ-028 frame_end = VGA_ready & pixel_x==H_LAST & pixel_y==V_LAST.
REQ-029 State machine: CLEAN (dirty==0), PENDING (dirty!=0), HELD (frame_end seen while PENDING and lock=1).
REQ-030 CLEAN->PENDING on any accepted write; PENDING->HELD on frame_end & lock; PENDING or HELD -> commit on frame_end & ~lock.
REQ-031 Commit SHALL copy all shadow to active in one edge, clear dirty, go to CLEAN, reset missed_frames to 0, assert commit_pulse the following cycle.
REQ-032 A write accepted in the commit cycle SHALL be included in active and SHALL NOT leave its dirty bit set.
REQ-033 frame_end in CLEAN SHALL not commit and SHALL not pulse commit_pulse.
REQ-034 Each frame_end & lock while PENDING/HELD SHALL increment missed_frames, saturating at 255.
REQ-035 HELD SHALL not commit when lock drops mid-frame; it waits for the next frame_end.
REQ-036 active_regs SHALL change only on commit edges or reset; never mid-frame.

Reset
REQ-037 rst=0 at an edge SHALL load shadow and active from RESET_VALS, clear dirty, state CLEAN, rd_data=0, rd_valid=0, commit_pulse=0, addr_err=0, missed_frames=0, overriding any same-cycle access or frame_end.

Verification
REQ-038 Reset, then read addr 6 -> rd_valid next cycle, rd_data=500; active_regs reg0=320.
REQ-039 Write addr 0 = 100, frame_end with lock=0 -> dirty[0] set then cleared, active reg0=100, commit_pulse one cycle after.
REQ-040 Set scores 5/7, write addr 9 = 1 -> shadow reg7=reg8=0, reg9=1; after commit active reg7=reg8=0.
REQ-041 Write addr 1 = 50, lock=1 across 3 frame_ends -> active reg1 unchanged, missed_frames=3; lock=0, next frame_end -> reg1=50, missed_frames=0.
REQ-042 Write addr 12 -> addr_err pulse, no dirty change; write addr 2 = 9 in the frame_end cycle -> active reg2=9, dirty=0.

Source files
------------

// File: rtl/frame_reg_bank_if.sv
// Register-bank bus: one access per cycle while chipselect is high, with
// registered read data, a read strobe and an address-error strobe returned.
interface frame_reg_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              chipselect;
    logic              read;
    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              addr_err;

    modport master (
        output chipselect, read, data_address, wr_data,
        input  rd_data, rd_valid, addr_err
    );

    modport slave (
        input  chipselect, read, data_address, wr_data,
        output rd_data, rd_valid, addr_err
    );
endinterface

// File: rtl/frame_reg_bank.sv
// Double-buffered game-state register bank. The bus writes a shadow copy.
// The shadow is copied to the active copy only at the end of a visible frame,
// so the renderer never sees a half-updated game state. A lock input can hold
// off the copy; frames skipped that way are counted.
module frame_reg_bank #(
    parameter int                         DATA_W         = 16,
    parameter int                         NUM_REGS       = 10,
    parameter int                         ADDR_W         = 4,
    parameter int                         H_LAST         = 639,
    parameter int                         V_LAST         = 479,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS     = {16'd0, 16'd0, 16'd0, 16'd500, 16'd240,
                                                            16'd320, 16'd240, 16'd320, 16'd240, 16'd320},
    parameter int                         CLEAR_TRIG_IDX = 9,
    parameter logic [NUM_REGS-1:0]        CLEAR_MASK     = 10'b0110000000,
    parameter bit                         READ_SRC       = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    frame_reg_bank_if.slave              bus,
    input  logic                         VGA_ready,
    input  logic [15:0]                  pixel_x,
    input  logic [15:0]                  pixel_y,
    input  logic                         lock,
    output logic [NUM_REGS*DATA_W-1:0]   active_regs,
    output logic                         commit_pulse,
    output logic [NUM_REGS-1:0]          dirty,
    output logic [7:0]                   missed_frames
);

    localparam logic [ADDR_W:0]   NUM_REGS_A = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] TRIG_A     = ADDR_W'(CLEAR_TRIG_IDX);
    localparam logic [15:0]       H_LAST_P   = 16'(H_LAST);
    localparam logic [15:0]       V_LAST_P   = 16'(V_LAST);

    // CLEAN: nothing written since the last commit. PENDING: unpublished
    // writes exist. HELD: a frame end passed while locked with data pending.
    typedef enum logic [1:0] {
        ST_CLEAN   = 2'd0,
        ST_PENDING = 2'd1,
        ST_HELD    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shadow_q [NUM_REGS];
    logic [DATA_W-1:0]   shadow_d [NUM_REGS];
    logic [DATA_W-1:0]   active_q [NUM_REGS];
    logic [DATA_W-1:0]   active_d [NUM_REGS];
    logic [NUM_REGS-1:0] dirty_q, dirty_d;
    logic [7:0]          missed_q, missed_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                addr_err_q, addr_err_d;
    logic                commit_pulse_q, commit_pulse_d;

    logic                in_range;
    logic                wr_ok;
    logic                rd_ok;
    logic                frame_end;
    logic                commit;

    // Decode the bus access and the last-visible-pixel event.
    always_comb begin
        in_range  = ({1'b0, bus.data_address} < NUM_REGS_A);
        wr_ok     = bus.chipselect & ~bus.read & in_range;
        rd_ok     = bus.chipselect & bus.read;
        frame_end = VGA_ready & (pixel_x == H_LAST_P) & (pixel_y == V_LAST_P);
    end

    // Next-state logic: bus writes/reads, commit FSM and the missed-frame counter.
    always_comb begin
        // NOTE: every signal gets its default first, so no path through this
        // block leaves one unassigned (which would infer a latch).
        state_d        = state_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        dirty_d        = dirty_q;
        missed_d       = missed_q;
        rd_data_d      = rd_data_q;
        rd_valid_d     = rd_ok;
        addr_err_d     = bus.chipselect & ~in_range;
        commit         = 1'b0;

        if (rd_ok) begin
            if (in_range) begin
                rd_data_d = READ_SRC ? active_q[bus.data_address] : shadow_q[bus.data_address];
            end else begin
                rd_data_d = '0;
            end
        end

        if (wr_ok) begin
            // A nonzero write to the trigger register starts a new round:
            // the masked registers clear first, then the trigger takes its value.
            if ((bus.data_address == TRIG_A) && (bus.wr_data != '0)) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (CLEAR_MASK[i]) begin
                        shadow_d[i] = '0;
                        dirty_d[i]  = 1'b1;
                    end
                end
            end
            shadow_d[bus.data_address] = bus.wr_data;
            dirty_d[bus.data_address]  = 1'b1;
        end

        case (state_q)
            ST_CLEAN: begin
                if (wr_ok) state_d = ST_PENDING;
            end
            ST_PENDING, ST_HELD: begin
                if (frame_end) begin
                    if (lock) begin
                        state_d  = ST_HELD;
                        missed_d = (missed_q == 8'hFF) ? missed_q : missed_q + 8'd1;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAN;
        endcase

        // Commit publishes shadow_d, so a write landing on the commit edge is
        // included and leaves nothing dirty behind.
        if (commit) begin
            active_d = shadow_d;
            dirty_d  = '0;
            missed_d = '0;
            state_d  = ST_CLEAN;
        end

        commit_pulse_d = commit;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q <= ST_CLEAN;
            // NOTE: these arrays are small flop banks rather than RAM, so they
            // are reset to give the game a defined starting state.
            for (int i = 0; i < NUM_REGS; i++) begin
                shadow_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
                active_q[i] <= RESET_VALS[i*DATA_W +: DATA_W];
            end
            dirty_q        <= '0;
            missed_q       <= '0;
            rd_data_q      <= '0;
            rd_valid_q     <= 1'b0;
            addr_err_q     <= 1'b0;
            commit_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            dirty_q        <= dirty_d;
            missed_q       <= missed_d;
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            addr_err_q     <= addr_err_d;
            commit_pulse_q <= commit_pulse_d;
        end
    end

    // Flatten the active array onto the output bus, reg0 in the LSBs.
    always_comb begin
        active_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            active_regs[i*DATA_W +: DATA_W] = active_q[i];
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.addr_err   = addr_err_q;
    assign commit_pulse   = commit_pulse_q;
    assign dirty          = dirty_q;
    assign missed_frames  = missed_q;

endmodule

// File: tb/tb_frame_reg_bank.sv
// Testbench for frame_reg_bank: directed scenarios plus a randomized run,
// checked against a register-level reference model of the double buffer.
module tb_frame_reg_bank;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 10;
    localparam int ADDR_W   = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       VGA_ready;
    logic [15:0]                pixel_x;
    logic [15:0]                pixel_y;
    logic                       lock;
    logic [NUM_REGS*DATA_W-1:0] active_regs;
    logic                       commit_pulse;
    logic [NUM_REGS-1:0]        dirty;
    logic [7:0]                 missed_frames;

    frame_reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    frame_reg_bank dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .VGA_ready     (VGA_ready),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .lock          (lock),
        .active_regs   (active_regs),
        .commit_pulse  (commit_pulse),
        .dirty         (dirty),
        .missed_frames (missed_frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: two plain arrays plus per-register written flags.
    int          reset_vals [NUM_REGS] = '{320, 240, 320, 240, 320, 240, 500, 0, 0, 0};
    logic [15:0] m_shadow [NUM_REGS];
    logic [15:0] m_active [NUM_REGS];
    bit          m_dirty  [NUM_REGS];
    int          m_missed;
    logic [15:0] m_rd_data;
    bit          m_rd_valid;
    bit          m_addr_err;
    bit          m_commit;

    function automatic bit m_pending();
        for (int i = 0; i < NUM_REGS; i++) if (m_dirty[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NUM_REGS-1:0] m_dirty_vec();
        logic [NUM_REGS-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i] = m_dirty[i];
        return v;
    endfunction

    function automatic logic [15:0] act(input int i);
        return active_regs[i*16 +: 16];
    endfunction

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge(input bit r, input bit cs, input bit rd, input int a,
                              input logic [15:0] d, input bit fe, input bit lk);
        bit pend;
        if (!r) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_shadow[i] = 16'(reset_vals[i]);
                m_active[i] = 16'(reset_vals[i]);
                m_dirty[i]  = 1'b0;
            end
            m_missed = 0; m_rd_data = '0; m_rd_valid = 0; m_addr_err = 0; m_commit = 0;
            return;
        end
        m_rd_valid = cs && rd;
        m_addr_err = cs && (a >= NUM_REGS);
        m_commit   = 1'b0;
        if (cs && rd) begin
            if (a < NUM_REGS) m_rd_data = m_shadow[a];
            else              m_rd_data = '0;
        end
        pend = m_pending();
        if (cs && !rd && a < NUM_REGS) begin
            // Nonzero write to register 9 zeroes the two score registers 7 and 8.
            if (a == 9 && d != 0) begin
                m_shadow[7] = '0; m_shadow[8] = '0;
                m_dirty[7]  = 1'b1; m_dirty[8] = 1'b1;
            end
            m_shadow[a] = d;
            m_dirty[a]  = 1'b1;
        end
        if (fe && pend) begin
            if (lk) begin
                if (m_missed < 255) m_missed++;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    m_active[i] = m_shadow[i];
                    m_dirty[i]  = 1'b0;
                end
                m_missed = 0;
                m_commit = 1'b1;
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then stop on
    // the falling edge where outputs are sampled.
    task automatic step(input bit r, input bit cs, input bit rd, input int a,
                        input logic [15:0] d, input bit fe, input bit lk);
        rst              = r;
        bus.chipselect   = cs;
        bus.read         = rd;
        bus.data_address = a[3:0];
        bus.wr_data      = d;
        lock             = lk;
        if (fe) begin
            VGA_ready = 1'b1; pixel_x = 16'd639; pixel_y = 16'd479;
        end else begin
            case ($urandom_range(0, 3))
                0:       begin VGA_ready = 1'b0; pixel_x = 16'd639; pixel_y = 16'd479; end
                1:       begin VGA_ready = 1'b1; pixel_x = 16'd639; pixel_y = 16'd478; end
                2:       begin VGA_ready = 1'b1; pixel_x = 16'd638; pixel_y = 16'd479; end
                default: begin
                    VGA_ready = 1'b1;
                    pixel_x   = 16'($urandom_range(0, 600));
                    pixel_y   = 16'($urandom_range(0, 400));
                end
            endcase
        end
        @(posedge clk);
        model_edge(r, cs, rd, a, d, fe, lk);
        @(negedge clk);
    endtask

    task automatic idle(input bit fe, input bit lk);
        step(1'b1, 1'b0, 1'b0, 0, 16'd0, fe, lk);
    endtask

    task automatic wr(input int a, input logic [15:0] d, input bit fe, input bit lk);
        step(1'b1, 1'b1, 1'b0, a, d, fe, lk);
    endtask

    task automatic rd(input int a);
        step(1'b1, 1'b1, 1'b1, a, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        // Reset wins over a simultaneous write and frame end.
        step(1'b0, 1'b1, 1'b0, 3, 16'hABCD, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 6, 16'h0000, 1'b1, 1'b0);
        n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 16'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0d want 0", bus.rd_data); end
        n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_commit_pulse: got %b want 0", commit_pulse); end
        n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", bus.addr_err); end
        n_checks++; if (missed_frames !== 8'd0) begin n_fail++; $display("FAIL reset_missed: got %0d want 0", missed_frames); end
        n_checks++; if (dirty !== '0) begin n_fail++; $display("FAIL reset_dirty: got %b want 0", dirty); end
        for (int i = 0; i < NUM_REGS; i++) begin
            n_checks++;
            if (act(i) !== 16'(reset_vals[i])) begin
                n_fail++; $display("FAIL reset_active%0d: got %0d want %0d", i, act(i), reset_vals[i]);
            end
        end
        rd(6);
        n_checks++; if (bus.rd_valid !== 1'b1) begin n_fail++; $display("FAIL read6_valid: got %b want 1", bus.rd_valid); end
        n_checks++; if (bus.rd_data !== 16'd500) begin n_fail++; $display("FAIL read6_data: got %0d want 500", bus.rd_data); end
        n_checks++; if (act(0) !== 16'd320) begin n_fail++; $display("FAIL reg0_after_reset: got %0d want 320", act(0)); end
    endtask

    task automatic test_commit();
        wr(0, 16'd100, 1'b0, 1'b0);
        n_checks++; if (dirty !== 10'b0000000001) begin n_fail++; $display("FAIL commit_dirty_set: got %b want 0000000001", dirty); end
        n_checks++; if (act(0) !== 16'd320) begin n_fail++; $display("FAIL commit_active_early: got %0d want 320", act(0)); end
        idle(1'b1, 1'b0);
        n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL commit_pulse_high: got %b want 1", commit_pulse); end
        n_checks++; if (act(0) !== 16'd100) begin n_fail++; $display("FAIL commit_reg0: got %0d want 100", act(0)); end
        n_checks++; if (dirty !== '0) begin n_fail++; $display("FAIL commit_dirty_clear: got %b want 0", dirty); end
        idle(1'b0, 1'b0);
        n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL commit_pulse_width: got %b want 0", commit_pulse); end
    endtask

    task automatic test_clear_trigger();
        wr(7, 16'd5, 1'b0, 1'b0);
        wr(8, 16'd7, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        n_checks++; if (act(7) !== 16'd5 || act(8) !== 16'd7) begin n_fail++; $display("FAIL scores_commit: got %0d/%0d want 5/7", act(7), act(8)); end
        wr(9, 16'd1, 1'b0, 1'b0);
        n_checks++; if (dirty !== 10'b1110000000) begin n_fail++; $display("FAIL clear_dirty: got %b want 1110000000", dirty); end
        rd(7);
        n_checks++; if (bus.rd_data !== 16'd0) begin n_fail++; $display("FAIL clear_shadow7: got %0d want 0", bus.rd_data); end
        rd(8);
        n_checks++; if (bus.rd_data !== 16'd0) begin n_fail++; $display("FAIL clear_shadow8: got %0d want 0", bus.rd_data); end
        rd(9);
        n_checks++; if (bus.rd_data !== 16'd1) begin n_fail++; $display("FAIL clear_shadow9: got %0d want 1", bus.rd_data); end
        n_checks++; if (act(7) !== 16'd5) begin n_fail++; $display("FAIL clear_active_early: got %0d want 5", act(7)); end
        idle(1'b1, 1'b0);
        n_checks++; if (act(7) !== 16'd0 || act(8) !== 16'd0 || act(9) !== 16'd1) begin
            n_fail++; $display("FAIL clear_commit: got %0d/%0d/%0d want 0/0/1", act(7), act(8), act(9));
        end
    endtask

    task automatic test_lock();
        wr(1, 16'd50, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1, 1'b1);
            n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL lock_no_pulse%0d: got %b want 0", k, commit_pulse); end
            idle(1'b0, 1'b1);
        end
        n_checks++; if (act(1) !== 16'd240) begin n_fail++; $display("FAIL lock_reg1_held: got %0d want 240", act(1)); end
        n_checks++; if (missed_frames !== 8'd3) begin n_fail++; $display("FAIL lock_missed3: got %0d want 3", missed_frames); end
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        n_checks++; if (act(1) !== 16'd240 || commit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL unlock_midframe: reg1=%0d pulse=%b want 240/0", act(1), commit_pulse);
        end
        idle(1'b1, 1'b0);
        n_checks++; if (act(1) !== 16'd50) begin n_fail++; $display("FAIL unlock_reg1: got %0d want 50", act(1)); end
        n_checks++; if (missed_frames !== 8'd0) begin n_fail++; $display("FAIL unlock_missed: got %0d want 0", missed_frames); end
        n_checks++; if (commit_pulse !== 1'b1) begin n_fail++; $display("FAIL unlock_pulse: got %b want 1", commit_pulse); end
    endtask

    task automatic test_addr_err();
        idle(1'b0, 1'b0);
        wr(12, 16'h1234, 1'b0, 1'b0);
        n_checks++; if (bus.addr_err !== 1'b1) begin n_fail++; $display("FAIL oor_write_err: got %b want 1", bus.addr_err); end
        n_checks++; if (dirty !== '0) begin n_fail++; $display("FAIL oor_write_dirty: got %b want 0", dirty); end
        idle(1'b0, 1'b0);
        n_checks++; if (bus.addr_err !== 1'b0) begin n_fail++; $display("FAIL oor_err_width: got %b want 0", bus.addr_err); end
        rd(13);
        n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'd0 || bus.addr_err !== 1'b1) begin
            n_fail++; $display("FAIL oor_read: valid=%b data=%0d err=%b want 1/0/1", bus.rd_valid, bus.rd_data, bus.addr_err);
        end
        rd(6);
        idle(1'b0, 1'b0);
        n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'd500) begin
            n_fail++; $display("FAIL rd_hold: valid=%b data=%0d want 0/500", bus.rd_valid, bus.rd_data);
        end
        idle(1'b1, 1'b0);
        n_checks++; if (commit_pulse !== 1'b0) begin n_fail++; $display("FAIL clean_frame_end: got %b want 0", commit_pulse); end
        wr(3, 16'd77, 1'b0, 1'b0);
        wr(2, 16'd9, 1'b1, 1'b0);
        n_checks++; if (act(2) !== 16'd9 || act(3) !== 16'd77) begin
            n_fail++; $display("FAIL commit_cycle_write: reg2=%0d reg3=%0d want 9/77", act(2), act(3));
        end
        n_checks++; if (dirty !== '0) begin n_fail++; $display("FAIL commit_cycle_dirty: got %b want 0", dirty); end
    endtask

    task automatic test_saturation();
        wr(4, 16'd1, 1'b0, 1'b0);
        for (int k = 0; k < 260; k++) idle(1'b1, 1'b1);
        n_checks++; if (missed_frames !== 8'd255) begin n_fail++; $display("FAIL missed_saturate: got %0d want 255", missed_frames); end
        n_checks++; if (act(4) !== 16'd320) begin n_fail++; $display("FAIL sat_reg4_held: got %0d want 320", act(4)); end
        idle(1'b1, 1'b0);
        n_checks++; if (missed_frames !== 8'd0 || act(4) !== 16'd1) begin
            n_fail++; $display("FAIL sat_release: missed=%0d reg4=%0d want 0/1", missed_frames, act(4));
        end
    endtask

    task automatic test_random();
        logic [NUM_REGS*DATA_W-1:0] exp_act;
        int a;
        logic [15:0] d;
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 3) != 0) ? $urandom_range(0, NUM_REGS - 1) : $urandom_range(NUM_REGS, 15);
            d = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 a, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            for (int i = 0; i < NUM_REGS; i++) exp_act[i*16 +: 16] = m_active[i];
            n_checks++; if (active_regs !== exp_act) begin n_fail++; $display("FAIL rand_active@%0d: got %h want %h", n, active_regs, exp_act); end
            n_checks++; if (dirty !== m_dirty_vec()) begin n_fail++; $display("FAIL rand_dirty@%0d: got %b want %b", n, dirty, m_dirty_vec()); end
            n_checks++; if (missed_frames !== 8'(m_missed)) begin n_fail++; $display("FAIL rand_missed@%0d: got %0d want %0d", n, missed_frames, m_missed); end
            n_checks++; if (commit_pulse !== m_commit) begin n_fail++; $display("FAIL rand_pulse@%0d: got %b want %b", n, commit_pulse, m_commit); end
            n_checks++; if (bus.rd_valid !== m_rd_valid || bus.rd_data !== m_rd_data) begin
                n_fail++; $display("FAIL rand_read@%0d: got %b/%h want %b/%h", n, bus.rd_valid, bus.rd_data, m_rd_valid, m_rd_data);
            end
            n_checks++; if (bus.addr_err !== m_addr_err) begin n_fail++; $display("FAIL rand_addr_err@%0d: got %b want %b", n, bus.addr_err, m_addr_err); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; bus.chipselect = 1'b0; bus.read = 1'b0; bus.data_address = '0; bus.wr_data = '0;
        VGA_ready = 1'b0; pixel_x = '0; pixel_y = '0; lock = 1'b0;
        test_reset();
        test_commit();
        test_clear_trigger();
        test_lock();
        test_addr_err();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
